// File: rtl/umi_pkg.sv
// Shared UMI constants and the packet record stored by the request buffer.
package umi_pkg;

    localparam int DEFAULT_DW    = 256;
    localparam int DEFAULT_AW    = 64;
    localparam int DEFAULT_CW    = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [DEFAULT_CW-1:0] cmd;
        logic [DEFAULT_AW-1:0] dstaddr;
        logic [DEFAULT_AW-1:0] srcaddr;
        logic [DEFAULT_DW-1:0] data;
    } umi_pkt_t;

endpackage

// File: rtl/umi_req_buffer_if.sv
// Upstream request and downstream memory handshakes of the UMI request buffer.
interface umi_req_buffer_if
    import umi_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW,
    parameter int CW = DEFAULT_CW
) ();

    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_cmd;
    logic [AW-1:0] in_dstaddr;
    logic [AW-1:0] in_srcaddr;
    logic [DW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dstaddr;
    logic [AW-1:0] out_srcaddr;
    logic [DW-1:0] out_data;

    modport slave (
        input  in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
        output in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data
    );

    modport master (
        output in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
        input  in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data
    );

endinterface

// File: rtl/umi_fifo_mem.sv
// Packet storage: synchronous write, asynchronous read, synchronous clear of every entry.
module umi_fifo_mem
    import umi_pkg::*;
#(
    parameter type T     = umi_pkt_t,
    parameter int  DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     clr_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  T                         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output T                         rdata_o
);

    T mem_q [DEPTH];

    // Clear has priority so a write attempted during reset never lands.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/umi_req_buffer.sv
// In-order request buffer between a UMI receive endpoint and a memory device.
module umi_req_buffer
    import umi_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int AW    = DEFAULT_AW,
    parameter int CW    = DEFAULT_CW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    umi_req_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] dstaddr;
        logic [AW-1:0] srcaddr;
        logic [DW-1:0] data;
    } pkt_t;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push_s, pop_s;
    pkt_t            wr_pkt_s, rd_pkt_s;

    // Ready depends only on registered fill level and reset, never on out_ready.
    assign bus.in_ready  = (count_q < CNT_FULL) && !rst;
    assign bus.out_valid = (count_q != '0);
    assign push_s        = bus.in_valid && bus.in_ready;
    assign pop_s         = bus.out_valid && bus.out_ready;

    assign wr_pkt_s.cmd     = bus.in_cmd;
    assign wr_pkt_s.dstaddr = bus.in_dstaddr;
    assign wr_pkt_s.srcaddr = bus.in_srcaddr;
    assign wr_pkt_s.data    = bus.in_data;

    assign bus.out_cmd     = rd_pkt_s.cmd;
    assign bus.out_dstaddr = rd_pkt_s.dstaddr;
    assign bus.out_srcaddr = rd_pkt_s.srcaddr;
    assign bus.out_data    = rd_pkt_s.data;
    assign count           = count_q;

    umi_fifo_mem #(
        .T     (pkt_t),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .clr_i   (rst),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_pkt_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_pkt_s)
    );

    // Pointer and fill-level registers; reset overrides any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

endmodule
